// File: rtl/nibbler_fetch.sv
// Fetch/sequencing stage of the 4-bit processor: PC, fetch register, C/Z flags, phase flop.
// Optional build macro NIBBLER_FETCH_HALT_EN adds a halt_i input that freezes all state.
module nibbler_fetch #(
  parameter int              PC_W     = 12,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            reset_i,
`ifdef NIBBLER_FETCH_HALT_EN
  input  logic            halt_i,
`endif
  input  logic [7:0]      prog_byte_i,
  input  logic            inc_pc_i,
  input  logic            load_pc_i,
  input  logic            load_fetch_i,
  input  logic            load_flags_i,
  input  logic            c_in_i,
  input  logic            z_in_i,
  output logic [PC_W-1:0] pc_o,
  output logic [3:0]      instr_o,
  output logic [3:0]      oprnd_o,
  output logic            phase_o,
  output logic            c_flag_o,
  output logic            z_flag_o,
  output logic [6:0]      dec_addr_o
);

  typedef enum logic {
    PH_FETCH = 1'b0,
    PH_EXEC  = 1'b1
  } phase_e;

  phase_e          phase_q, phase_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      fetch_q, fetch_d;
  logic            c_q, c_d;
  logic            z_q, z_d;
  logic            run;

`ifdef NIBBLER_FETCH_HALT_EN
  assign run = ~halt_i;
`else
  assign run = 1'b1;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      phase_q <= PH_FETCH;
      pc_q    <= RESET_PC;
      fetch_q <= 8'h00;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      phase_q <= phase_d;
      pc_q    <= pc_d;
      fetch_q <= fetch_d;
      c_q     <= c_d;
      z_q     <= z_d;
    end
  end

  // Jump target uses the operand nibble already held, so it must be read before any fetch update.
  always_comb begin
    phase_d = phase_q;
    pc_d    = pc_q;
    fetch_d = fetch_q;
    c_d     = c_q;
    z_d     = z_q;
    if (run) begin
      phase_d = (phase_q == PH_FETCH) ? PH_EXEC : PH_FETCH;
      if (load_pc_i) begin
        pc_d = PC_W'({fetch_q[3:0], prog_byte_i});
      end else if (inc_pc_i) begin
        pc_d = pc_q + PC_W'(1);
      end
      if (load_fetch_i && (phase_q == PH_FETCH)) begin
        fetch_d = prog_byte_i;
      end
      if (load_flags_i && (phase_q == PH_EXEC)) begin
        c_d = c_in_i;
        z_d = z_in_i;
      end
    end
  end

  assign pc_o       = pc_q;
  assign instr_o    = fetch_q[7:4];
  assign oprnd_o    = fetch_q[3:0];
  assign phase_o    = (phase_q == PH_EXEC);
  assign c_flag_o   = c_q;
  assign z_flag_o   = z_q;
  assign dec_addr_o = {fetch_q[7:4], c_q, z_q, phase_o};

endmodule

// File: tb/tb_nibbler_fetch.sv
// Self-checking bench for nibbler_fetch: directed vectors, per-cycle model compare, literal pins.
// Define NIBBLER_FETCH_HALT_EN for both RTL and bench to exercise the halt feature.
module tb_nibbler_fetch;

  logic        clk = 1'b0;
  logic        rst_s, ld_pc_s, inc_s, ld_f_s, ld_fl_s, c_s, z_s, halt_s;
  logic [7:0]  pb_s;
  logic [11:0] pc_w;
  logic [3:0]  instr_w, oprnd_w;
  logic        phase_w, c_w, z_w;
  logic [6:0]  dec_w;

  int tests = 0;
  int fails = 0;

  // Behavioural model of the architectural state
  int          m_pc;
  int          m_fetch;
  int          m_phase;
  int          m_c, m_z;
  bit          m_valid = 1'b0;

  always #5 clk = ~clk;

  nibbler_fetch dut (
    .clk_i        (clk),
    .reset_i      (rst_s),
`ifdef NIBBLER_FETCH_HALT_EN
    .halt_i       (halt_s),
`endif
    .prog_byte_i  (pb_s),
    .inc_pc_i     (inc_s),
    .load_pc_i    (ld_pc_s),
    .load_fetch_i (ld_f_s),
    .load_flags_i (ld_fl_s),
    .c_in_i       (c_s),
    .z_in_i       (z_s),
    .pc_o         (pc_w),
    .instr_o      (instr_w),
    .oprnd_o      (oprnd_w),
    .phase_o      (phase_w),
    .c_flag_o     (c_w),
    .z_flag_o     (z_w),
    .dec_addr_o   (dec_w)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic ldpc, input logic inc, input logic ldf,
                               input logic ldfl, input logic c, input logic z, input logic [7:0] pb);
    rst_s   = rst;
    ld_pc_s = ldpc;
    inc_s   = inc;
    ld_f_s  = ldf;
    ld_fl_s = ldfl;
    c_s     = c;
    z_s     = z;
    pb_s    = pb;
    @(posedge clk);
    #1;
  endtask

  // Model update from the spec's rules, in plain integer arithmetic
  always @(posedge clk) begin
    int  nxt_pc;
    bit  halted;
`ifdef NIBBLER_FETCH_HALT_EN
    halted = (halt_s === 1'b1);
`else
    halted = 1'b0;
`endif
    if (rst_s === 1'b1) begin
      m_pc = 0; m_fetch = 0; m_phase = 0; m_c = 0; m_z = 0;
      m_valid = 1'b1;
    end else if (!halted) begin
      if (ld_pc_s)     nxt_pc = (m_fetch % 16) * 256 + int'(pb_s);
      else if (inc_s)  nxt_pc = (m_pc + 1) % 4096;
      else             nxt_pc = m_pc;
      if (ld_f_s && m_phase == 0)  m_fetch = int'(pb_s);
      if (ld_fl_s && m_phase == 1) begin m_c = int'(c_s); m_z = int'(z_s); end
      m_pc    = nxt_pc;
      m_phase = 1 - m_phase;
    end
  end

  // Every meaningful cycle, compare all outputs against the model
  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("pc",       32'(pc_w),    32'(m_pc));
      checkOutput("fetchreg", {24'h0, instr_w, oprnd_w}, 32'(m_fetch));
      checkOutput("phase",    32'(phase_w), 32'(m_phase));
      checkOutput("flags",    {30'h0, c_w, z_w}, 32'(m_c * 2 + m_z));
      checkOutput("dec_addr", 32'(dec_w),   32'((m_fetch / 16) * 8 + m_c * 4 + m_z * 2 + m_phase));
    end
  end

  initial begin
    halt_s = 1'b0;
    // Reset held two cycles with conflicting PC controls
    applyStimulus(1, 1, 1, 1, 1, 1, 1, 8'hFF);
    applyStimulus(1, 1, 1, 1, 1, 1, 1, 8'hFF);
    checkOutput("rst_pc",    32'(pc_w),    32'h000);
    checkOutput("rst_phase", 32'(phase_w), 32'h0);
    checkOutput("rst_dec",   32'(dec_w),   32'h00);

    // Sequential fetch
    applyStimulus(0, 0, 1, 1, 0, 0, 0, 8'h5A);
    checkOutput("seq_instr", 32'(instr_w), 32'h5);
    checkOutput("seq_oprnd", 32'(oprnd_w), 32'hA);
    checkOutput("seq_pc",    32'(pc_w),    32'h001);
    checkOutput("seq_dec",   32'(dec_w),   32'b0101001);

    // Flags gating: ignored in phase 0, captured in phase 1
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 8'h00);
    applyStimulus(0, 0, 0, 0, 1, 1, 1, 8'h00);
    checkOutput("flags_ph0", {30'h0, c_w, z_w}, 32'h0);
    applyStimulus(0, 0, 0, 0, 1, 1, 1, 8'h00);
    checkOutput("flags_ph1", {30'h0, c_w, z_w}, 32'h3);
    checkOutput("flags_dec", 32'(dec_w), 32'b0101110);

    // Jump with load_pc and inc_pc together; fetch in phase 1 ignored
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 8'h93);
    applyStimulus(0, 1, 1, 1, 0, 0, 0, 8'hC4);
    checkOutput("jump_pc",    32'(pc_w),    32'h3C4);
    checkOutput("jump_instr", 32'(instr_w), 32'h9);

    // Wrap at 0xFFF
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 8'h8F);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 8'hFF);
    checkOutput("pre_wrap_pc", 32'(pc_w), 32'hFFF);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 8'h00);
    checkOutput("wrap_pc", 32'(pc_w), 32'h000);

    // Reset mid-phase-1 with load_fetch
    checkOutput("pre_rst_phase", 32'(phase_w), 32'h1);
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 8'h77);
    checkOutput("midrst_instr", 32'(instr_w), 32'h0);
    checkOutput("midrst_phase", 32'(phase_w), 32'h0);
    checkOutput("midrst_flags", {30'h0, c_w, z_w}, 32'h0);

    // Short program fragment
    applyStimulus(0, 0, 1, 1, 0, 0, 0, 8'h2B);
    applyStimulus(0, 0, 1, 0, 1, 1, 0, 8'h00);
    applyStimulus(0, 0, 0, 1, 1, 0, 1, 8'hE1);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 8'h50);
    checkOutput("prog_pc",  32'(pc_w),  32'h150);
    checkOutput("prog_dec", 32'(dec_w), 32'b1110100);

`ifdef NIBBLER_FETCH_HALT_EN
    halt_s = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 0, 0, 0, 8'hAA);
    checkOutput("halt_pc",    32'(pc_w),    32'h150);
    checkOutput("halt_phase", 32'(phase_w), 32'h0);
    checkOutput("halt_instr", 32'(instr_w), 32'hE);
    halt_s = 1'b0;
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 8'h00);
    checkOutput("resume_phase", 32'(phase_w), 32'h1);
    checkOutput("resume_pc",    32'(pc_w),    32'h151);
`endif

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 8'h00);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 8'h00);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nibbler_fetch.md
# nibbler_fetch

Fetch and sequencing stage of the 4-bit processor, directly upstream of the opcode control ROM. Holds the 12-bit program counter, the 8-bit fetch register (instruction/operand nibbles), the C/Z flags register and the phase flip-flop. It also assembles the 7-bit decode address the control ROM consumes. It acts on the control-word bits the ROM returns (PC increment, PC load, fetch load, flags load), closing the fetch/execute loop.

## Interface
- PC_W, 12, program counter and program-memory address width
- RESET_PC, 12'h000, PC value loaded on reset
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- prog_byte  in  8  program memory data at address `pc` (combinational memory, valid same cycle)
- inc_pc  in  1  control word: increment PC
- load_pc  in  1  control word: load PC with jump target
- load_fetch  in  1  control word: capture `prog_byte` into the fetch register
- load_flags  in  1  control word: capture `c_in`/`z_in`
- c_in  in  1  ALU carry out
- z_in  in  1  ALU zero out
- pc  out  PC_W  program memory address
- instr  out  4  fetch register [7:4]
- oprnd  out  4  fetch register [3:0]
- phase  out  1  0 = fetch, 1 = execute
- c_flag  out  1  registered carry
- z_flag  out  1  registered zero
- dec_addr  out  7  {instr, c_flag, z_flag, phase} to the control ROM

## Operation
- Phase flip-flop toggles every cycle: 0,1,0,1…
- Fetch register: loads `prog_byte` on a clock edge with `load_fetch`=1 and `phase`=0; ignored in phase 1.
- Flags register: loads {c_in, z_in} on a clock edge with `load_flags`=1 and `phase`=1; ignored in phase 0.
- PC next-value priority:
  - `load_pc`=1 → {oprnd, prog_byte} (jump target: operand nibble as high 4 bits, second program byte as low 8).
  - else `inc_pc`=1 → pc+1, modulo 2^PC_W (0xFFF → 0x000, no flag).
  - else hold.
  - Both `load_pc` and `inc_pc` asserted: load wins.
- PC updates are accepted in either phase. A two-byte jump uses phase-0 increment, then phase-1 load.
- `dec_addr` is purely combinational from registered state, with no dependency on any input port.
- Control inputs are sampled only at the rising edge. The block places no constraint on how long they are held.

## Timing
- Reset (sync), outputs after the first edge with reset=1: pc=RESET_PC, instr=0, oprnd=0, phase=0, c_flag=0, z_flag=0, dec_addr=7'b0000000.
- Reset asserted mid-instruction: the same values apply at the next edge, overriding all load/inc inputs. The first cycle after release is a fetch (phase 0).
- Fetch latency: `prog_byte` captured at the end of the phase-0 cycle. The new `instr` appears on `dec_addr` in the following phase-1 cycle.
- Flags written in phase 1 are visible on `dec_addr` in the next phase-0 cycle and throughout the following instruction's phase 1.
- PC change appears on `pc` one cycle after the controlling edge. The program memory returns the new `prog_byte` in that same cycle.
- One instruction = exactly 2 cycles (or 2 cycles per phase pair when halted is deasserted).

## Configuration
- NIBBLER_FETCH_HALT_EN defined: adds input `halt` (1 bit).
  - While `halt`=1, phase, PC, fetch register and flags all hold, regardless of control inputs.
  - `halt` is sampled at the edge. Reset overrides halt.
- Undefined: no `halt` port. Phase toggles unconditionally.

## Test plan
- Reset: hold reset 2 cycles with load_pc=1, inc_pc=1 → pc=0x000, phase=0, instr=0, flags=0, dec_addr=0.
- Sequential fetch: prog_byte=0x5A in phase 0, load_fetch=1, inc_pc=1 → next cycle instr=4'h5, oprnd=4'hA, pc=0x001, phase=1, dec_addr={0101,0,0,1}.
- Flags gating:
  - c_in=1, z_in=1, load_flags=1 in phase 0 → flags stay 0.
  - Same stimulus in phase 1 → c_flag=1, z_flag=1 next cycle.
  - Next phase-0 dec_addr bit0=0, bits[2:1]=11.
- Jump: oprnd=4'h3, prog_byte=0xC4, load_pc=1 and inc_pc=1 together → pc=0x3C4 next cycle.
- Wrap: pc=0xFFF, inc_pc=1 → pc=0x000. Reset mid-phase-1 with load_fetch=1 → instr=0, phase=0.
- Halt (NIBBLER_FETCH_HALT_EN): halt=1 for 3 cycles with inc_pc=1, load_fetch=1 → pc, phase, instr unchanged. Release → toggling resumes from the held phase.
